// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - start/status, round-key stream and store read port of aes_key_expander
interface aes_key_expander_if;
   logic         start_in;
   logic [1:0]   mode_in;
   logic [255:0] key_in;
   logic         busy_out;
   logic         err_out;
   logic         rk_valid_out;
   logic         rk_ready_in;
   logic [127:0] rk_data_out;
   logic [3:0]   rk_round_out;
   logic         done_out;
   logic [3:0]   num_rounds_out;
   logic [3:0]   rd_addr_in;
   logic [127:0] rd_data_out;

   modport slave (
      input  start_in, mode_in, key_in, rk_ready_in, rd_addr_in,
      output busy_out, err_out, rk_valid_out, rk_data_out, rk_round_out,
             done_out, num_rounds_out, rd_data_out
   );

   modport master (
      output start_in, mode_in, key_in, rk_ready_in, rd_addr_in,
      input  busy_out, err_out, rk_valid_out, rk_data_out, rk_round_out,
             done_out, num_rounds_out, rd_data_out
   );
endinterface

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES-128/192/256 key schedule, one word per cycle
// Round keys stream out over valid/ready and are optionally kept for reverse-order readback.
module aes_key_expander #(
   parameter int MAX_KEY_BITS = 256,
   parameter bit STORE_KEYS   = 1'b1
) (
   input logic               clk_in,
   input logic               rst_in,
   aes_key_expander_if.slave bus
);

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Byte 0x00 sits in the top byte of the table, so index from the MSB end.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] base;
      base = {~b, 3'b000};
      return SBOX_TABLE[base +: 8];
   endfunction

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_d;
   logic [255:0]  key_q;
   logic [31:0]   win [8];
   logic [95:0]   acc;
   logic [5:0]    i_q;
   logic [2:0]    kcnt;
   logic [7:0]    rcon;
   logic [3:0]    nk_q;
   logic [5:0]    nw_q;
   logic [3:0]    nr_q;
   logic          busy_q, err_q, done_q, rk_valid_q;
   logic [127:0]  rk_data_q, rd_q;
   logic [3:0]    rk_round_q;

   logic          legal, accept, reject, finish;
   logic          handshake, stall, gen, load, first, sub8;
   logic [7:0]    kbase;
   logic [31:0]   key_word, prev, back, sub_in, sub, t, w_new;

   always_comb begin
      legal = 1'b0;
      case (bus.mode_in)
         2'd0:    legal = 1'b1;
         2'd1:    legal = (MAX_KEY_BITS >= 192);
         2'd2:    legal = (MAX_KEY_BITS >= 256);
         default: legal = 1'b0;
      endcase
   end

   assign handshake = rk_valid_q && bus.rk_ready_in;
   assign stall     = (i_q[1:0] == 2'b11) && rk_valid_q && !bus.rk_ready_in;
   assign gen       = (state == RUN) && (i_q < nw_q) && !stall;
   assign load      = gen && (i_q[1:0] == 2'b11);

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      reject  = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start_in) begin
               if (legal) begin
                  accept  = 1'b1;
                  state_d = RUN;
               end else begin
                  reject  = 1'b1;
               end
            end
         end
         RUN: begin
            if (handshake && (rk_round_q == nr_q)) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // win[7] is w[i-1]; w[i-Nk] therefore sits at win[8-Nk].
   always_comb begin
      kbase    = ~{i_q[2:0], 5'b00000};
      key_word = key_q[kbase -: 32];
      prev     = win[7];
      case (nk_q)
         4'd4:    back = win[4];
         4'd6:    back = win[2];
         default: back = win[0];
      endcase
      first  = (i_q >= {2'b00, nk_q}) && (kcnt == 3'd0);
      sub8   = (i_q >= {2'b00, nk_q}) && (nk_q == 4'd8) && (kcnt == 3'd4);
      sub_in = first ? {prev[23:0], prev[31:24]} : prev;
      sub    = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
      if (first)
         t = sub ^ {rcon, 24'h0};
      else if (sub8)
         t = sub;
      else
         t = prev;
      w_new = (i_q < {2'b00, nk_q}) ? key_word : (back ^ t);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         state <= IDLE;
      else
         state <= state_d;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         key_q      <= '0;
         acc        <= '0;
         i_q        <= '0;
         kcnt       <= '0;
         rcon       <= '0;
         nk_q       <= '0;
         nw_q       <= '0;
         nr_q       <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         rk_valid_q <= 1'b0;
         rk_data_q  <= '0;
         rk_round_q <= '0;
         for (int k = 0; k < 8; k++) win[k] <= '0;
      end else begin
         err_q  <= reject;
         done_q <= finish;
         if (accept) begin
            key_q  <= bus.key_in;
            i_q    <= '0;
            kcnt   <= '0;
            rcon   <= 8'h01;
            busy_q <= 1'b1;
            case (bus.mode_in)
               2'd0:    begin nk_q <= 4'd4; nr_q <= 4'd10; nw_q <= 6'd44; end
               2'd1:    begin nk_q <= 4'd6; nr_q <= 4'd12; nw_q <= 6'd52; end
               default: begin nk_q <= 4'd8; nr_q <= 4'd14; nw_q <= 6'd60; end
            endcase
         end
         if (gen) begin
            for (int k = 0; k < 7; k++) win[k] <= win[k+1];
            win[7] <= w_new;
            acc    <= {acc[63:0], w_new};
            i_q    <= i_q + 6'd1;
            kcnt   <= ({1'b0, kcnt} == nk_q - 4'd1) ? 3'd0 : kcnt + 3'd1;
            if (first)
               rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         // A key may load in the same cycle the previous one is taken.
         if (load) begin
            rk_data_q  <= {acc, w_new};
            rk_round_q <= i_q[5:2];
            rk_valid_q <= 1'b1;
         end else if (handshake) begin
            rk_valid_q <= 1'b0;
         end
         if (finish)
            busy_q <= 1'b0;
      end
   end

   generate
      if (STORE_KEYS) begin : g_store
         logic [127:0] store [15];

         always_ff @(posedge clk_in) begin
            if (load)
               store[i_q[5:2]] <= {acc, w_new};
         end

         always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in)
               rd_q <= '0;
            else if (bus.rd_addr_in > nr_q)
               rd_q <= '0;
            else
               rd_q <= store[bus.rd_addr_in];
         end
      end else begin : g_no_store
         assign rd_q = '0;
      end
   endgenerate

   assign bus.busy_out       = busy_q;
   assign bus.err_out        = err_q;
   assign bus.done_out       = done_q;
   assign bus.rk_valid_out   = rk_valid_q;
   assign bus.rk_data_out    = rk_data_q;
   assign bus.rk_round_out   = rk_round_q;
   assign bus.num_rounds_out = nr_q;
   assign bus.rd_data_out    = rd_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - self-checking bench for aes_key_expander against a word-array key schedule model
module tb_aes_key_expander;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_key_expander_if bus ();

   aes_key_expander #(.MAX_KEY_BITS(256), .STORE_KEYS(1'b1)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   int compared = 0;
   int mismatched = 0;

   logic [7:0]   sb [256];
   logic [7:0]   rcon_tab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [127:0] exp_rk [15];
   int           nr_m;
   logic [127:0] got_rk [$];
   logic [3:0]   got_round [$];
   int           fs [15];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
   task automatic init_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   task automatic build(input logic [1:0] mode, input logic [255:0] key);
      int nk;
      logic [31:0] w [60];
      logic [31:0] t;
      nk   = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 6 : 8;
      nr_m = nk + 6;
      for (int i = 0; i < 4 * (nr_m + 1); i++) begin
         if (i < nk) begin
            w[i] = key[255 - 32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0)
               t = subword({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk], 24'h0};
            else if (nk == 8 && i % 8 == 4)
               t = subword(t);
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r <= nr_m; r++)
         exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic run_op(input logic [1:0] mode, input logic [255:0] key, input int ready_pct,
                         input bit noise, input string tag);
      int c, done_cycle;
      bit prev_stall, rdy, fin;
      logic [127:0] prev_data;
      logic [3:0] prev_round;
      build(mode, key);
      got_rk.delete();
      got_round.delete();
      for (int k = 0; k < 15; k++) fs[k] = -1;
      bus.mode_in = mode; bus.key_in = key; bus.start_in = 1'b1;
      @(posedge clk); #1;
      bus.start_in = 1'b0;
      c = 0; done_cycle = -1; prev_stall = 1'b0; fin = 1'b0;
      prev_data = '0; prev_round = '0;
      check({tag, " busy_rise"}, 128'(bus.busy_out), 128'(1));
      check({tag, " num_rounds"}, 128'(bus.num_rounds_out), 128'(nr_m));
      while (!fin && c < 2000) begin
         if (prev_stall) begin
            check({tag, " hold_data"}, bus.rk_data_out, prev_data);
            check({tag, " hold_round"}, 128'(bus.rk_round_out), 128'(prev_round));
            check({tag, " hold_valid"}, 128'(bus.rk_valid_out), 128'(1));
         end
         check({tag, " done"}, 128'(bus.done_out), 128'(c == done_cycle));
         if (c == done_cycle) begin
            check({tag, " busy_fall"}, 128'(bus.busy_out), 128'(0));
            check({tag, " valid_clear"}, 128'(bus.rk_valid_out), 128'(0));
            fin = 1'b1;
         end else begin
            if (noise) check({tag, " no_err_in_run"}, 128'(bus.err_out), 128'(0));
            if (bus.rk_valid_out && fs[bus.rk_round_out] < 0) fs[bus.rk_round_out] = c;
            rdy = ($urandom_range(99) < ready_pct);
            bus.rk_ready_in = rdy;
            if (noise) begin
               bus.start_in = 1'($urandom_range(1));
               bus.mode_in  = 2'd3;
            end
            if (bus.rk_valid_out && rdy) begin
               got_rk.push_back(bus.rk_data_out);
               got_round.push_back(bus.rk_round_out);
               if (bus.rk_round_out == 4'(nr_m)) done_cycle = c + 1;
            end
            prev_stall = bus.rk_valid_out && !rdy;
            prev_data  = bus.rk_data_out;
            prev_round = bus.rk_round_out;
            @(posedge clk); #1;
            c++;
         end
      end
      bus.start_in = 1'b0;
      bus.rk_ready_in = 1'b1;
      check({tag, " finished"}, 128'(fin), 128'(1));
      check({tag, " key_count"}, 128'(got_rk.size()), 128'(nr_m + 1));
      for (int k = 0; k < got_rk.size() && k <= nr_m; k++) begin
         check($sformatf("%s round_idx%0d", tag, k), 128'(got_round[k]), 128'(k));
         check($sformatf("%s rk%0d", tag, k), got_rk[k], exp_rk[k]);
      end
      if (ready_pct >= 100) begin
         check({tag, " rk0_latency"}, 128'(fs[0]), 128'(4));
         check({tag, " last_latency"}, 128'(fs[nr_m]), 128'(4 * (nr_m + 1)));
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start_in = 1'b0; bus.mode_in = 2'd0; bus.key_in = '0;
      bus.rk_ready_in = 1'b1; bus.rd_addr_in = 4'd0;
      init_sbox();
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", 128'(bus.busy_out), 128'(0));
      check("rst err", 128'(bus.err_out), 128'(0));
      check("rst valid", 128'(bus.rk_valid_out), 128'(0));
      check("rst data", bus.rk_data_out, 128'(0));
      check("rst round", 128'(bus.rk_round_out), 128'(0));
      check("rst done", 128'(bus.done_out), 128'(0));
      check("rst nr", 128'(bus.num_rounds_out), 128'(0));
      check("rst rd", bus.rd_data_out, 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(2'd0, KEY128, 100, 1'b0, "aes128");
      check("aes128 rk0 is key", got_rk[0], KEY128[255:128]);
      check("aes128 rk10 fips", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      for (int a = 10; a >= 0; a--) begin
         bus.rd_addr_in = 4'(a);
         @(posedge clk); #1;
         check($sformatf("readback%0d", a), bus.rd_data_out, exp_rk[a]);
      end
      bus.rd_addr_in = 4'd11;
      @(posedge clk); #1;
      check("readback11 zero", bus.rd_data_out, 128'(0));

      bus.mode_in = 2'd3; bus.start_in = 1'b1;
      @(posedge clk); #1;
      bus.start_in = 1'b0;
      check("illegal err", 128'(bus.err_out), 128'(1));
      check("illegal busy", 128'(bus.busy_out), 128'(0));
      @(posedge clk); #1;
      check("illegal err_pulse", 128'(bus.err_out), 128'(0));
      check("illegal busy2", 128'(bus.busy_out), 128'(0));

      run_op(2'd1, KEY192, 100, 1'b0, "aes192");
      check("aes192 rk12 fips", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

      run_op(2'd2, KEY256, 100, 1'b0, "aes256");
      check("aes256 rk14 fips", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

      run_op(2'd2, KEY256, 40, 1'b1, "aes256_bp");
      for (int n = 0; n < 3; n++) begin
         run_op(2'(n), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                30 + 30 * n, 1'b1, $sformatf("rand_m%0d", n));
      end

      bus.mode_in = 2'd1; bus.key_in = KEY192; bus.start_in = 1'b1; bus.rk_ready_in = 1'b1;
      @(posedge clk); #1;
      bus.start_in = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("pre_abort busy", 128'(bus.busy_out), 128'(1));
      rst = 1'b1;
      #1;
      check("abort busy", 128'(bus.busy_out), 128'(0));
      check("abort valid", 128'(bus.rk_valid_out), 128'(0));
      check("abort data", bus.rk_data_out, 128'(0));
      check("abort round", 128'(bus.rk_round_out), 128'(0));
      check("abort done", 128'(bus.done_out), 128'(0));
      check("abort nr", 128'(bus.num_rounds_out), 128'(0));
      check("abort rd", bus.rd_data_out, 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(2'd0, KEY128, 100, 1'b0, "post_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative, parametrised AES key expansion engine supporting AES-128, AES-192 and AES-256, selected per operation.
- Computes one 32-bit schedule word per cycle (FIPS-197 KeyExpansion) through a shared 32-bit aes_sbox slice.
- Streams 128-bit round keys out over a valid/ready handshake.
- Optionally retains all round keys in an internal store for random-access readback, used for reverse-order decryption.

Parameters:
- MAX_KEY_BITS, 256, largest key size supported (128, 192 or 256). Modes above this are rejected.
- STORE_KEYS, 1, 1 instantiates the 15x128 round-key store and read port. 0 ties rd_data_out to 0.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-high
- start_in  input  1  start pulse; sampled only in IDLE
- mode_in  input  2  key size: 0=128, 1=192, 2=256, 3=illegal
- key_in  input  256  cipher key, MSB-aligned (AES-128 uses [255:128], AES-192 uses [255:64])
- busy_out  output  1  high from accepted start until the last round key is accepted
- err_out  output  1  one-cycle pulse when a start is rejected
- rk_valid_out  output  1  round-key output register holds a key
- rk_ready_in  input  1  consumer accepts the key on valid&&ready
- rk_data_out  output  128  round key, word w[4r] in [127:96]
- rk_round_out  output  4  round index r of rk_data_out
- done_out  output  1  one-cycle pulse on the handshake of the final round key
- num_rounds_out  output  4  Nr of the latched mode (10/12/14); 0 after reset
- rd_addr_in  input  4  store read address (round index)
- rd_data_out  output  128  registered store read data, 1-cycle latency

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, store contents don't-care. Asserting reset mid-operation aborts immediately with no done_out pulse.
- Mode constants:
  - Nk = 4, 6 or 8.
  - Nr = 10, 12 or 14.
  - Total words W = 4(Nr+1) = 44, 52 or 60.
  - Rcon[j] = 01,02,04,08,10,20,40,80,1b,36 for j = 1..10.
- FSM IDLE:
  - On start_in with a legal mode ≤ MAX_KEY_BITS: latch mode and key into the Nk-word window, clear the word counter i, set busy_out, go to RUN.
  - On start_in with an illegal mode: err_out pulses for one cycle, state stays IDLE.
- FSM RUN: each un-stalled cycle produces word w[i] and increments i.
  - i < Nk: w[i] = key word i.
  - Otherwise let t = w[i-1].
    - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {Rcon[i/Nk], 24'h0}.
    - Else if Nk == 8 and i mod 8 == 4: t = SubWord(t).
    - Then w[i] = w[i-Nk] ^ t.
  - The window is a shift register of the last Nk words.
  - Words accumulate four at a time. When i mod 4 == 3, the assembled key loads rk_data_out and rk_round_out = i/4, rk_valid_out is set, and the key is written to store address i/4 if STORE_KEYS.
- Latency and stall:
  - With rk_ready_in held high, round key r becomes valid 4(r+1) cycles after the start edge.
  - The last key becomes valid W cycles after the start edge.
  - Stall: a cycle with i mod 4 == 3 is held (i not incremented) while rk_valid_out && !rk_ready_in. Other word cycles continue, so the next key is pre-computed except for its last word.
  - Accepting a key in the same cycle a new one loads is legal: valid stays high with the new data.
- Completion:
  - Handshake of round Nr pulses done_out, clears busy_out and rk_valid_out, and returns to IDLE.
  - start_in during RUN is ignored with no err_out pulse.
- Store read port:
  - rd_data_out is registered from rd_addr_in every cycle.
  - Addresses > Nr of the latched mode return 0.
  - Contents persist until overwritten by the next operation. Reads during RUN of an address already written return the new key.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_in=1 -> rk0 equals the key at cycle 4; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 44; done_out pulses; busy_out falls.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 keys with rk_round_out 0..12; rk12 = e98ba06f448c773c8ecc720401002202 at cycle 52; num_rounds_out = 12.
- AES-256, key 603deb10...0914dff4 (FIPS A.3) -> rk14 = fe4890d1e6188d0b046df344706c631e at cycle 60; the i mod 8 == 4 SubWord path is exercised.
- Random rk_ready_in backpressure on AES-256 -> the key sequence is identical to the unstalled run; no key is dropped or duplicated; the output holds stable while valid && !ready.
- After the AES-128 run, read rd_addr_in 10..0 -> data one cycle later matches the streamed keys; addr 11 returns 0. Then mode_in=3 -> err_out pulses for one cycle and busy_out stays 0.
- Assert rst_in at cycle 20 of an AES-192 run -> all outputs 0 immediately; a following AES-128 start produces the correct rk0 at cycle 4.
